// File: rtl/alu_b_port_bank.sv
// Bank of CHANNELS ALU B operand registers, loaded from the internal bus.
// A write is captured on every clk edge that samples the nwalu strobe low.
// It commits when the strobe's rising edge is seen.
// Parameter limits: WIDTH >= 9, CHANNELS >= 1, 2**SELW >= CHANNELS.
// Ports:
//   clk       system clock, rising edge
//   nreset    synchronous active-low reset
//   nwalu     active-low write strobe; commit on its low-to-high transition
//   ibus      internal bus data
//   mode      load mode: 00 load, 01 complement, 10 zero-extend, 11 sign-extend byte
//   wsel      channel to write, captured with the data
//   rsel      channel driving b, ibus_out and valid
//   nralu     active-low read-back request
//   b         selected operand (combinational mux)
//   ibus_out  registered read-back data
//   ibus_oe   registered read-back drive enable
//   valid     selected channel has been written since reset (combinational)
module alu_b_port_bank #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SELW     = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             nwalu,
    input  logic [WIDTH-1:0] ibus,
    input  logic [1:0]       mode,
    input  logic [SELW-1:0]  wsel,
    input  logic [SELW-1:0]  rsel,
    input  logic             nralu,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ibus_out,
    output logic             ibus_oe,
    output logic             valid
);

    localparam int unsigned EXTW = WIDTH - 8;

    logic [WIDTH-1:0]    regs [CHANNELS];
    logic [CHANNELS-1:0] valid_flags;
    logic                nwalu_q;
    logic [WIDTH-1:0]    hold_data;
    logic [1:0]          hold_mode;
    logic [SELW-1:0]     hold_sel;
    logic                strobe_rise;
    logic [WIDTH-1:0]    load_value;
    logic [WIDTH-1:0]    b_sel;
    logic                valid_sel;

    // Strobe rising edge; nwalu_q resets high so nothing commits straight out of reset.
    assign strobe_rise = !nwalu_q && nwalu;

    // Load-mode transform applied to the held data at commit time.
    always_comb begin
        load_value = hold_data;
        case (hold_mode)
            2'b00:   load_value = hold_data;
            2'b01:   load_value = ~hold_data;
            2'b10:   load_value = {{EXTW{1'b0}}, hold_data[7:0]};
            2'b11:   load_value = {{EXTW{hold_data[7]}}, hold_data[7:0]};
            default: load_value = hold_data;
        endcase
    end

    // Read mux; an out-of-range rsel reads as zero and not valid.
    always_comb begin
        b_sel     = '0;
        valid_sel = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(rsel) == i) begin
                b_sel     = regs[i];
                valid_sel = valid_flags[i];
            end
        end
    end

    assign b     = b_sel;
    assign valid = valid_sel;

    // Strobe sampling, capture of the last low cycle, and registered read-back.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            nwalu_q   <= 1'b1;
            hold_data <= '0;
            hold_mode <= '0;
            hold_sel  <= '0;
            ibus_out  <= '0;
            ibus_oe   <= 1'b0;
        end else begin
            nwalu_q <= nwalu;
            if (!nwalu) begin
                hold_data <= ibus;
                hold_mode <= mode;
                hold_sel  <= wsel;
            end
            ibus_oe  <= ~nralu;
            // Read-back uses the pre-commit register contents on a coincident write.
            ibus_out <= nralu ? '0 : b_sel;
        end
    end

    // Commit into the addressed channel; an out-of-range hold_sel matches nothing.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                regs[i] <= '0;
            end
            valid_flags <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (strobe_rise && (32'(hold_sel) == i)) begin
                    regs[i]        <= load_value;
                    valid_flags[i] <= 1'b1;
                end
            end
        end
    end

endmodule
